// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit bit engine: bit timer, LSB-first serialiser, bit stuffing, NRZI and line drive.
// Optional build macro TX_DATA_TOGGLE_EN alternates the DATA PID between DATA0 and DATA1 after each data packet.
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int STUFF_LEN    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timer_en,
   input  logic       load_data,
   input  logic [2:0] bit_type,
   input  logic [7:0] tx_byte,
   output logic       shift_en,
   output logic       cnt_7bits,
   output logic       dplus,
   output logic       dminus
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int OW = $clog2(STUFF_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

   localparam logic [2:0] BT_IDLE = 3'b000;
   localparam logic [2:0] BT_SYNC = 3'b001;
   localparam logic [2:0] BT_ACK  = 3'b010;
   localparam logic [2:0] BT_NAK  = 3'b011;
   localparam logic [2:0] BT_STLL = 3'b100;
   localparam logic [2:0] BT_DATA = 3'b101;
   localparam logic [2:0] BT_BYTE = 3'b110;
   localparam logic [2:0] BT_EOP  = 3'b111;

   logic [CW-1:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [OW-1:0] ones_cnt, ones_nxt, ones_inc;
   logic [7:0]    shift_reg, shift_nxt, sel_byte, data_pid;
   logic          stuff, stuff_nxt;
   logic          level, level_nxt;
   logic          dplus_nxt, dminus_nxt, shift_en_nxt, cnt_7bits_nxt;
   logic          bit_end, stuffable, line_update, tx_bit;

`ifdef TX_DATA_TOGGLE_EN
   logic data_tgl, data_seen, prev_eop;

   // The PID flips once the line returns to idle after an EOP that closed a data packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_tgl  <= 1'b0;
         data_seen <= 1'b0;
         prev_eop  <= 1'b0;
      end else begin
         prev_eop <= (bit_type == BT_EOP);
         if (prev_eop && bit_type == BT_IDLE && data_seen) begin
            data_tgl  <= ~data_tgl;
            data_seen <= 1'b0;
         end else if (bit_type == BT_DATA) begin
            data_seen <= 1'b1;
         end
      end
   end

   assign data_pid = data_tgl ? 8'h4B : 8'hC3;
`else
   assign data_pid = 8'hC3;
`endif

   assign bit_end   = timer_en && (clk_cnt == CNT_MAX);
   assign stuffable = (bit_type != BT_IDLE) && (bit_type != BT_EOP);

   always_comb begin
      sel_byte = 8'h00;
      case (bit_type)
         BT_SYNC: sel_byte = 8'h80;
         BT_ACK:  sel_byte = 8'hD2;
         BT_NAK:  sel_byte = 8'h5A;
         BT_STLL: sel_byte = 8'h1E;
         BT_DATA: sel_byte = data_pid;
         BT_BYTE: sel_byte = tx_byte;
         default: sel_byte = 8'h00;
      endcase
   end

   // tx_bit is the bit that goes on the wire in the period starting next cycle.
   always_comb begin
      clk_cnt_nxt  = clk_cnt;
      bit_idx_nxt  = bit_idx;
      ones_nxt     = ones_cnt;
      ones_inc     = '0;
      shift_nxt    = shift_reg;
      stuff_nxt    = stuff;
      shift_en_nxt = 1'b0;
      line_update  = 1'b0;
      tx_bit       = shift_reg[0];

      if (!timer_en) begin
         clk_cnt_nxt = '0;
         bit_idx_nxt = '0;
      end else begin
         clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
      end

      if (load_data) begin
         shift_nxt    = sel_byte;
         bit_idx_nxt  = '0;
         stuff_nxt    = 1'b0;
         tx_bit       = sel_byte[0];
         line_update  = 1'b1;
         shift_en_nxt = bit_end && !stuff;
         if (bit_type == BT_SYNC) ones_nxt = '0;
      end else if (bit_end) begin
         line_update = 1'b1;
         if (stuff) begin
            stuff_nxt = 1'b0;
         end else begin
            shift_en_nxt = 1'b1;
            bit_idx_nxt  = bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
               shift_nxt = sel_byte;
               tx_bit    = sel_byte[0];
            end else begin
               shift_nxt = {1'b0, shift_reg[7:1]};
               tx_bit    = shift_reg[1];
            end
            if (stuffable) begin
               ones_inc = shift_reg[0] ? ones_cnt + 1'b1 : '0;
               if (ones_inc == ONES_MAX) begin
                  stuff_nxt = 1'b1;
                  ones_nxt  = '0;
                  tx_bit    = 1'b0;
               end else begin
                  ones_nxt = ones_inc;
               end
            end
         end
      end

      level_nxt  = level;
      dplus_nxt  = dplus;
      dminus_nxt = dminus;
      if (line_update) begin
         level_nxt  = tx_bit ? level : ~level;
         dplus_nxt  = level_nxt;
         dminus_nxt = ~level_nxt;
      end

      // EOP takes effect at a period boundary; idle forces J immediately (abort path).
      if (bit_type == BT_EOP) begin
         level_nxt = 1'b1;
         ones_nxt  = '0;
         stuff_nxt = 1'b0;
         if (line_update) begin
            dplus_nxt  = 1'b0;
            dminus_nxt = 1'b0;
         end
      end else if (bit_type == BT_IDLE) begin
         level_nxt  = 1'b1;
         ones_nxt   = '0;
         stuff_nxt  = 1'b0;
         dplus_nxt  = 1'b1;
         dminus_nxt = 1'b0;
      end

      cnt_7bits_nxt = timer_en && (bit_idx_nxt == 3'd7);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_cnt   <= '0;
         bit_idx   <= '0;
         ones_cnt  <= '0;
         shift_reg <= '0;
         stuff     <= 1'b0;
         level     <= 1'b1;
         dplus     <= 1'b1;
         dminus    <= 1'b0;
         shift_en  <= 1'b0;
         cnt_7bits <= 1'b0;
      end else begin
         clk_cnt   <= clk_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         ones_cnt  <= ones_nxt;
         shift_reg <= shift_nxt;
         stuff     <= stuff_nxt;
         level     <= level_nxt;
         dplus     <= dplus_nxt;
         dminus    <= dminus_nxt;
         shift_en  <= shift_en_nxt;
         cnt_7bits <= cnt_7bits_nxt;
      end
   end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: the bench plays the TX packet FSM and checks line states per bit period.
module tb_usb_tx_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       timer_en;
   logic       load_data;
   logic [2:0] bit_type;
   logic [7:0] tx_byte;
   logic       shift_en;
   logic       cnt_7bits;
   logic       dplus;
   logic       dminus;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] LJ = 2'b10;
   localparam logic [1:0] LK = 2'b01;
   localparam logic [1:0] LS = 2'b00;

   always #5 clk = ~clk;

   usb_tx_encoder #(.CLKS_PER_BIT(8), .STUFF_LEN(6)) dut (
      .clk(clk),
      .rst(rst),
      .timer_en(timer_en),
      .load_data(load_data),
      .bit_type(bit_type),
      .tx_byte(tx_byte),
      .shift_en(shift_en),
      .cnt_7bits(cnt_7bits),
      .dplus(dplus),
      .dminus(dminus)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic go_quiet();
      timer_en  = 1'b0;
      load_data = 1'b0;
      bit_type  = 3'b000;
      repeat (3) tick();
   endtask

   // One idle bit period, then load SYNC on its bit-end; returns at the first SYNC period start.
   task automatic start_packet();
      timer_en  = 1'b1;
      bit_type  = 3'b000;
      load_data = 1'b0;
      repeat (7) tick();
      load_data = 1'b1;
      bit_type  = 3'b001;
      tick();
      load_data = 1'b0;
   endtask

   // Samples the period start, then runs one 8-clock period; mid changes bit_type mid-period.
   task automatic period(input logic [2:0] mid, input logic idle_end,
                         output logic [1:0] line, output logic pulse,
                         output logic c7, output int extra);
      line  = {dplus, dminus};
      pulse = shift_en;
      c7    = cnt_7bits;
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) bit_type = mid;
         if (c == 7 && idle_end) bit_type = 3'b000;
         @(negedge clk);
         if (c < 7 && shift_en) extra++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; timer_en = 1'b1; load_data = 1'b1; bit_type = 3'b011; tx_byte = 8'h00;
      repeat (2) tick();
      checks++;
      if ({dplus, dminus} !== LJ) begin errors++; $display("FAIL reset_line: got %b expected %b", {dplus, dminus}, LJ); end
      checks++;
      if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b expected 0", shift_en); end
      checks++;
      if (cnt_7bits !== 1'b0) begin errors++; $display("FAIL reset_cnt7: got %b expected 0", cnt_7bits); end
      rst = 1'b0;
      go_quiet();
   endtask

   task automatic test_ack();
      logic [1:0] exp_line [18] = '{LK,LJ,LK,LJ,LK,LJ,LK,LK, LJ,LJ,LK,LJ,LJ,LK,LK,LK, LS,LS};
      logic [1:0] line;
      logic pulse, c7;
      int extra;
      logic [2:0] mid;
      start_packet();
      for (int p = 0; p < 18; p++) begin
         mid = (p < 7) ? 3'b001 : (p < 15) ? 3'b010 : 3'b111;
         period(mid, p == 17, line, pulse, c7, extra);
         checks++;
         if (line !== exp_line[p]) begin errors++; $display("FAIL ack_line p%0d: got %b expected %b", p, line, exp_line[p]); end
         checks++;
         if (pulse !== 1'b1 || extra != 0) begin errors++; $display("FAIL ack_pulse p%0d: got start=%b extra=%0d expected start=1 extra=0", p, pulse, extra); end
         checks++;
         if (c7 !== (p == 7 || p == 15)) begin errors++; $display("FAIL ack_cnt7 p%0d: got %b expected %b", p, c7, (p == 7 || p == 15)); end
      end
      checks++;
      if ({dplus, dminus} !== LJ || shift_en !== 1'b1) begin
         errors++; $display("FAIL ack_after_eop: got line=%b pulse=%b expected line=%b pulse=1", {dplus, dminus}, shift_en, LJ);
      end
      go_quiet();
   endtask

   task automatic test_data_stuff();
      logic [1:0] exp_line [27] = '{LK,LJ,LK,LJ,LK,LJ,LK,LK, LK,LK,LJ,LK,LJ,LK,LK,LK,
                                    LK,LK,LK,LK, LJ, LJ,LJ,LJ,LJ, LS,LS};
      logic [1:0] line;
      logic pulse, c7;
      int extra;
      logic [2:0] mid;
      tx_byte = 8'hFF;
      start_packet();
      for (int p = 0; p < 27; p++) begin
         mid = (p < 7) ? 3'b001 : (p < 15) ? 3'b101 : (p < 24) ? 3'b110 : 3'b111;
         period(mid, p == 26, line, pulse, c7, extra);
         checks++;
         if (line !== exp_line[p]) begin errors++; $display("FAIL stuff_line p%0d: got %b expected %b", p, line, exp_line[p]); end
         checks++;
         if (pulse !== (p != 21) || extra != 0) begin
            errors++; $display("FAIL stuff_pulse p%0d: got start=%b extra=%0d expected start=%b extra=0", p, pulse, extra, (p != 21));
         end
         checks++;
         if (c7 !== (p == 7 || p == 15 || p == 24)) begin
            errors++; $display("FAIL stuff_cnt7 p%0d: got %b expected %b", p, c7, (p == 7 || p == 15 || p == 24));
         end
      end
      checks++;
      if ({dplus, dminus} !== LJ) begin errors++; $display("FAIL stuff_after_eop: got %b expected %b", {dplus, dminus}, LJ); end
      go_quiet();
   endtask

   task automatic test_reset_mid();
      logic [1:0] line;
      logic pulse, c7;
      int extra;
      start_packet();
      for (int p = 0; p < 11; p++) period((p < 7) ? 3'b001 : 3'b011, 1'b0, line, pulse, c7, extra);
      checks++;
      if ({dplus, dminus} !== LK) begin errors++; $display("FAIL nak_bit3_line: got %b expected %b", {dplus, dminus}, LK); end
      repeat (7) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({dplus, dminus} !== LJ) begin errors++; $display("FAIL rst_mid_line: got %b expected %b", {dplus, dminus}, LJ); end
      checks++;
      if (shift_en !== 1'b0 || cnt_7bits !== 1'b0) begin
         errors++; $display("FAIL rst_mid_strobes: got shift_en=%b cnt7=%b expected 0 0", shift_en, cnt_7bits);
      end
      rst = 1'b0;
      go_quiet();
      start_packet();
      period(3'b001, 1'b0, line, pulse, c7, extra);
      checks++;
      if (line !== LK) begin errors++; $display("FAIL rst_mid_sync_bit0: got %b expected %b", line, LK); end
      period(3'b001, 1'b0, line, pulse, c7, extra);
      checks++;
      if (line !== LJ) begin errors++; $display("FAIL rst_mid_sync_bit1: got %b expected %b", line, LJ); end
      go_quiet();
   endtask

   task automatic test_abort();
      logic [1:0] line;
      logic pulse, c7;
      int extra, stray, first;
      tx_byte = 8'hA5;
      start_packet();
      for (int p = 0; p < 11; p++) period((p < 7) ? 3'b001 : 3'b110, 1'b0, line, pulse, c7, extra);
      checks++;
      if ({dplus, dminus} !== LK) begin errors++; $display("FAIL abort_pre_line: got %b expected %b", {dplus, dminus}, LK); end
      repeat (3) tick();
      bit_type = 3'b000;
      timer_en = 1'b0;
      tick();
      checks++;
      if ({dplus, dminus} !== LJ) begin errors++; $display("FAIL abort_line: got %b expected %b", {dplus, dminus}, LJ); end
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (shift_en) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL abort_no_strobe: got %0d pulses expected 0", stray); end
      timer_en = 1'b1;
      first = 0;
      for (int i = 1; i <= 16 && first == 0; i++) begin
         tick();
         if (shift_en) first = i;
      end
      checks++;
      if (first != 8) begin errors++; $display("FAIL abort_restart: got first pulse at clock %0d expected 8", first); end
      go_quiet();
   endtask

   task automatic test_toggle();
      logic [1:0] line, prev;
      logic pulse, c7;
      int extra;
      logic [7:0] pid, exp_pid;
      logic [2:0] mid;
      for (int k = 0; k < 2; k++) begin
`ifdef TX_DATA_TOGGLE_EN
         exp_pid = (k == 0) ? 8'hC3 : 8'h4B;
`else
         exp_pid = 8'hC3;
`endif
         pid  = 8'h00;
         prev = LJ;
         start_packet();
         for (int p = 0; p < 18; p++) begin
            mid = (p < 7) ? 3'b001 : (p < 15) ? 3'b101 : 3'b111;
            period(mid, p == 17, line, pulse, c7, extra);
            if (p >= 8 && p <= 15) pid[p-8] = (line == prev);
            prev = line;
         end
         checks++;
         if (pid !== exp_pid) begin errors++; $display("FAIL toggle_pid pkt%0d: got %h expected %h", k, pid, exp_pid); end
         checks++;
         if ({dplus, dminus} !== LJ) begin errors++; $display("FAIL toggle_idle pkt%0d: got %b expected %b", k, {dplus, dminus}, LJ); end
         go_quiet();
      end
   endtask

   initial begin
      test_reset();
      test_ack();
      test_data_stuff();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      test_reset_mid();
      test_abort();
      test_toggle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
